// File: rtl/sb_rx_pkg.sv
// Shared definitions for the sideband RX packet path: header field positions,
// data-bearing opcode list, packet record and assembler FSM states.
package sb_rx_pkg;

  localparam int SB_OPC_W  = 5;
  localparam int SB_CP_BIT = 62;
  localparam int SB_DP_BIT = 63;

  // Opcodes that are followed by exactly one 64-bit payload word
  localparam logic [SB_OPC_W-1:0] SB_OPC_D00001 = 5'b00001;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D00011 = 5'b00011;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D00101 = 5'b00101;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D01001 = 5'b01001;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D01011 = 5'b01011;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D01101 = 5'b01101;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D10001 = 5'b10001;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D11001 = 5'b11001;
  localparam logic [SB_OPC_W-1:0] SB_OPC_D11011 = 5'b11011;

  function automatic logic sb_has_data(input logic [SB_OPC_W-1:0] opcode);
    logic hd;
    hd = 1'b0;
    case (opcode)
      SB_OPC_D00001, SB_OPC_D00011, SB_OPC_D00101,
      SB_OPC_D01001, SB_OPC_D01011, SB_OPC_D01101,
      SB_OPC_D10001, SB_OPC_D11001, SB_OPC_D11011: hd = 1'b1;
      default:                                     hd = 1'b0;
    endcase
    return hd;
  endfunction

  typedef struct packed {
    logic [63:0] hdr;
    logic [63:0] data;
    logic        has_data;
    logic        cp_err;
    logic        dp_err;
  } sb_pkt_t;

  typedef enum logic {
    SB_ST_IDLE      = 1'b0,
    SB_ST_WAIT_DATA = 1'b1
  } sb_rx_state_e;

endpackage

// File: rtl/sb_rx_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO for assembled sideband packets.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_flush sync clear;
//   i_push/i_wdata write side; i_pop read side (ignored when empty);
//   o_rdata head entry; o_empty/o_full status; o_drop 1-cycle pulse after a
//   push was discarded because the FIFO was full with no same-cycle pop.
module sb_rx_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drop_q;
  logic             do_push, do_pop, drop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = i_push & (~o_full | do_pop);
  assign drop    = i_push & o_full & ~do_pop;
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_drop  = drop_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= drop;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only meaningful while not empty
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/sb_rx_pkt_assembler.sv
// Sideband RX packet assembler: turns deserialized 64-bit words into
// header(+payload) packets, checks CP/DP even parity, times out a missing
// payload and queues packets in a FWFT FIFO.
// Ports: i_clk, i_rst_n (async active-low), i_flush (sync clear);
//   i_word/i_word_vld input words; o_pkt_* FIFO head (zero when empty),
//   o_pkt_vld/i_pkt_rdy pop handshake; o_overflow, o_timeout 1-cycle pulses;
//   o_busy high while waiting for a payload word.
//
// state        | meaning
// SB_ST_IDLE      | next word is a header
// SB_ST_WAIT_DATA | header held, next word is its payload; timer running
module sb_rx_pkt_assembler
  import sb_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic [63:0] i_word,
  input  logic        i_word_vld,
  output logic [63:0] o_pkt_hdr,
  output logic [63:0] o_pkt_data,
  output logic        o_pkt_has_data,
  output logic        o_pkt_cp_err,
  output logic        o_pkt_dp_err,
  output logic        o_pkt_vld,
  input  logic        i_pkt_rdy,
  output logic        o_overflow,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  sb_rx_state_e     state_q, state_d;
  logic [63:0]      hdr_q, hdr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  sb_pkt_t          pkt_q, pkt_d, head;
  logic             push_q, push_d;
  logic             timeout_q, timeout_d;
  logic             fifo_empty, fifo_full;

  function automatic sb_pkt_t make_pkt(input logic [63:0] hdr, input logic [63:0] data,
                                       input logic has_data);
    sb_pkt_t p;
    p.hdr      = hdr;
    p.data     = has_data ? data : 64'd0;
    p.has_data = has_data;
    p.cp_err   = (^hdr[SB_CP_BIT-1:0]) != hdr[SB_CP_BIT];
    p.dp_err   = has_data & ((^data) != hdr[SB_DP_BIT]);
    return p;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= SB_ST_IDLE;
      hdr_q     <= '0;
      timer_q   <= '0;
      pkt_q     <= '0;
      push_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (i_flush) begin
      state_q   <= SB_ST_IDLE;
      hdr_q     <= '0;
      timer_q   <= '0;
      pkt_q     <= '0;
      push_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      timer_q   <= timer_d;
      pkt_q     <= pkt_d;
      push_q    <= push_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    timer_d   = timer_q;
    pkt_d     = pkt_q;
    push_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      SB_ST_IDLE: begin
        if (i_word_vld) begin
          hdr_d = i_word;
          if (sb_has_data(i_word[SB_OPC_W-1:0])) begin
            state_d = SB_ST_WAIT_DATA;
            timer_d = '0;
          end else begin
            pkt_d  = make_pkt(i_word, 64'd0, 1'b0);
            push_d = 1'b1;
          end
        end
      end
      SB_ST_WAIT_DATA: begin
        // A word in the final timer cycle still completes the packet
        if (i_word_vld) begin
          pkt_d   = make_pkt(hdr_q, i_word, 1'b1);
          push_d  = 1'b1;
          state_d = SB_ST_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = SB_ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = SB_ST_IDLE;
    endcase
  end

  sb_rx_pkt_fifo #(
    .WIDTH ($bits(sb_pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (push_q),
    .i_wdata (pkt_q),
    .i_pop   (o_pkt_vld & i_pkt_rdy),
    .o_rdata (head),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_drop  (o_overflow)
  );

  // Head is masked so a drained FIFO shows zeros rather than stale storage
  assign o_pkt_vld      = ~fifo_empty;
  assign o_pkt_hdr      = o_pkt_vld ? head.hdr      : 64'd0;
  assign o_pkt_data     = o_pkt_vld ? head.data     : 64'd0;
  assign o_pkt_has_data = o_pkt_vld & head.has_data;
  assign o_pkt_cp_err   = o_pkt_vld & head.cp_err;
  assign o_pkt_dp_err   = o_pkt_vld & head.dp_err;
  assign o_timeout      = timeout_q;
  assign o_busy         = (state_q == SB_ST_WAIT_DATA);

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_sb_rx_pkt_assembler.sv
module tb_sb_rx_pkt_assembler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 256;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic [63:0] i_word;
  logic        i_word_vld;
  logic [63:0] o_pkt_hdr, o_pkt_data;
  logic        o_pkt_has_data, o_pkt_cp_err, o_pkt_dp_err, o_pkt_vld;
  logic        i_pkt_rdy;
  logic        o_overflow, o_timeout, o_busy;

  sb_rx_pkt_assembler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_word(i_word), .i_word_vld(i_word_vld),
    .o_pkt_hdr(o_pkt_hdr), .o_pkt_data(o_pkt_data),
    .o_pkt_has_data(o_pkt_has_data), .o_pkt_cp_err(o_pkt_cp_err),
    .o_pkt_dp_err(o_pkt_dp_err), .o_pkt_vld(o_pkt_vld), .i_pkt_rdy(i_pkt_rdy),
    .o_overflow(o_overflow), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] hdr;
    logic [63:0] data;
    logic        hd;
    logic        cp;
    logic        dp;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_pend_pkt, mon_e;
  bit   m_pend, m_wait, m_pop, m_full, exp_ovf, exp_to, mon_en;
  int   m_cnt;
  logic [63:0] m_hdr;
  int   checks = 0, failures = 0;
  int   ovf_cnt = 0, to_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit tb_has_data(input logic [4:0] opc);
    logic [4:0] lst [9] = '{5'b00001, 5'b00011, 5'b00101, 5'b01001, 5'b01011,
                            5'b01101, 5'b10001, 5'b11001, 5'b11011};
    foreach (lst[k]) if (lst[k] == opc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t build(input logic [63:0] h, input logic [63:0] d, input bit hd);
    exp_t e;
    e.hdr  = h;
    e.hd   = hd;
    e.data = hd ? d : 64'd0;
    e.cp   = (^h[61:0]) != h[62];
    e.dp   = hd ? ((^d) != h[63]) : 1'b0;
    return e;
  endfunction

  // Header with chosen opcode; CP/DP bits set right or deliberately wrong
  function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input logic [63:0] data,
                                         input bit cp_ok, input bit dp_ok);
    logic [63:0] h;
    h      = {$urandom, $urandom};
    h[4:0] = opc;
    h[63]  = (^data) ^ !dp_ok;
    h[62]  = (^h[61:0]) ^ !cp_ok;
    return h;
  endfunction

  // Reference model: packet collection, write one edge after completion, FIFO queue
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_q.delete();
      m_pend = 0; m_wait = 0; m_cnt = 0; exp_ovf = 0; exp_to = 0;
    end else begin
      exp_ovf = 0;
      exp_to  = 0;
      if (i_flush) begin
        exp_q.delete();
        m_pend = 0; m_wait = 0;
      end else begin
        m_pop  = i_pkt_rdy && exp_q.size() > 0;
        m_full = exp_q.size() == DEPTH;
        if (m_pop) void'(exp_q.pop_front());
        if (m_pend) begin
          if (m_full && !m_pop) exp_ovf = 1;
          else exp_q.push_back(m_pend_pkt);
        end
        m_pend = 0;
        if (i_word_vld) begin
          if (!m_wait) begin
            if (tb_has_data(i_word[4:0])) begin
              m_wait = 1; m_hdr = i_word; m_cnt = 0;
            end else begin
              m_pend_pkt = build(i_word, 64'd0, 0); m_pend = 1;
            end
          end else begin
            m_pend_pkt = build(m_hdr, i_word, 1); m_pend = 1; m_wait = 0;
          end
        end else if (m_wait) begin
          m_cnt++;
          if (m_cnt == TIMEOUT) begin exp_to = 1; m_wait = 0; end
        end
      end
    end
  end

  // Monitor: compare DUT head against scoreboard front whenever it presents a packet
  always @(negedge i_clk) begin
    if (mon_en) begin
      chk("pkt_vld", o_pkt_vld, exp_q.size() != 0);
      if (o_pkt_vld && exp_q.size() != 0) begin
        mon_e = exp_q[0];
        chk("pkt_hdr", o_pkt_hdr, mon_e.hdr);
        chk("pkt_data", o_pkt_data, mon_e.data);
        chk("pkt_has_data", o_pkt_has_data, mon_e.hd);
        chk("pkt_cp_err", o_pkt_cp_err, mon_e.cp);
        chk("pkt_dp_err", o_pkt_dp_err, mon_e.dp);
      end else if (!o_pkt_vld) begin
        chk("empty_hdr_zero", o_pkt_hdr | o_pkt_data, 64'd0);
        chk("empty_flags_zero", {o_pkt_has_data, o_pkt_cp_err, o_pkt_dp_err}, 64'd0);
      end
      chk("busy", o_busy, m_wait);
      chk("overflow", o_overflow, exp_ovf);
      chk("timeout", o_timeout, exp_to);
      if (o_overflow) ovf_cnt++;
      if (o_timeout) to_cnt++;
    end
  end

  task automatic word(input logic [63:0] w);
    i_word = w; i_word_vld = 1'b1;
    @(negedge i_clk);
    i_word_vld = 1'b0; i_word = 64'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  logic [63:0] d, h;
  int r, rdy_pct;

  initial begin
    i_rst_n = 1'b1; i_flush = 1'b0; i_word = 64'd0; i_word_vld = 1'b0; i_pkt_rdy = 1'b0;
    #1 i_rst_n = 1'b0;
    mon_en = 1;
    idle(3);
    i_rst_n = 1'b1;
    idle(1);

    // 1: message without payload
    word(mk_hdr(5'b10010, 64'd0, 1, 1));
    idle(2);
    chk("t1_vld", o_pkt_vld, 1);
    i_pkt_rdy = 1'b1; idle(1); i_pkt_rdy = 1'b0;

    // 2: data-bearing header then payload, clean parity
    d = 64'hDEAD_BEEF_0123_4567;
    word(mk_hdr(5'b01001, d, 1, 1));
    word(d);
    idle(2);
    chk("t2_has_data", o_pkt_has_data, 1);
    i_pkt_rdy = 1'b1; idle(1); i_pkt_rdy = 1'b0;

    // 3: both parities wrong
    d = {$urandom, $urandom};
    word(mk_hdr(5'b00001, d, 0, 0));
    word(d);
    idle(2);
    chk("t3_errs", {o_pkt_cp_err, o_pkt_dp_err}, 2'b11);
    i_pkt_rdy = 1'b1; idle(1);

    // 4: payload never arrives, then payload in the final allowed cycle
    to_cnt = 0;
    word(mk_hdr(5'b11011, 64'd0, 1, 1));
    idle(TIMEOUT);
    chk("t4_timeout_now", o_timeout, 1);
    idle(2);
    d = {$urandom, $urandom};
    word(mk_hdr(5'b11011, d, 1, 1));
    idle(TIMEOUT - 1);
    word(d);
    idle(3);
    chk("t4_timeout_cnt", to_cnt, 1);

    // 5: overflow with consumer stalled, then full + pop + push together
    i_pkt_rdy = 1'b0; ovf_cnt = 0;
    for (int k = 0; k < 5; k++) word(mk_hdr(5'b00000 + 5'(2 * k), 64'd0, 1, 1));
    idle(3);
    chk("t5_ovf_cnt", ovf_cnt, 1);
    word(mk_hdr(5'b10100, 64'd0, 1, 1));
    i_pkt_rdy = 1'b1; idle(1); i_pkt_rdy = 1'b0;
    idle(3);
    chk("t5_ovf_cnt_pop", ovf_cnt, 1);
    chk("t5_still_full_vld", o_pkt_vld, 1);

    // 6: flush while waiting with packets queued, then async reset mid-packet
    i_pkt_rdy = 1'b1; idle(6); i_pkt_rdy = 1'b0;
    word(mk_hdr(5'b00010, 64'd0, 1, 1));
    word(mk_hdr(5'b00110, 64'd0, 1, 1));
    word(mk_hdr(5'b00011, 64'd0, 1, 1));
    idle(3);
    chk("t6_busy_before", o_busy, 1);
    i_flush = 1'b1; i_word_vld = 1'b1; i_word = 64'h1; i_pkt_rdy = 1'b1;
    idle(1);
    i_flush = 1'b0; i_word_vld = 1'b0; i_pkt_rdy = 1'b0;
    chk("t6_flush_vld", o_pkt_vld, 0);
    word(mk_hdr(5'b01101, 64'd0, 1, 1));
    #2 i_rst_n = 1'b0;
    idle(1);
    chk("t6_rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    idle(2);

    // Random traffic against the reference model
    rdy_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rdy_pct = $urandom_range(10, 100);
      r = $urandom_range(0, 999);
      i_flush    = (r < 6);
      i_pkt_rdy  = ($urandom_range(0, 99) < rdy_pct);
      i_word_vld = ($urandom_range(0, 99) < 45);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) d[4:0] = 5'b01011;
      i_word = d;
      if (r >= 996) begin
        i_word_vld = 1'b0; i_flush = 1'b0;
        idle(TIMEOUT + 4);
      end else begin
        idle(1);
      end
    end
    i_word_vld = 1'b0; i_flush = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
